// File: rtl/instruction_loader_pkg.sv
// Shared constants for the instruction loader: FSM state encodings, word
// geometry and the default end-of-program marker.
package instruction_loader_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReceive = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } loader_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Bytes per instruction word; the byte index is 2 bits wide.
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Byte assembler: shifts received bytes in MSB-first and flags the byte that
// completes a word. The completed word is presented combinationally
// alongside that byte so the caller can capture it on the same edge.
module byte_assembler
    import instruction_loader_pkg::*;
#(
    parameter int unsigned NB      = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NB_BYTE-1:0] rx_byte,
    input  logic               accept,
    input  logic               clear,
    output logic [NB-1:0]      word,
    output logic               word_ready
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [NB-1:0] shift_q;
    logic [1:0]    idx_q;

    // Word as it stands once the current byte is shifted in.
    assign word       = {shift_q[NB-NB_BYTE-1:0], rx_byte};
    assign word_ready = accept && (idx_q == LAST_IDX);

    // Shift register and byte index; the index wraps to 0 after the last byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            shift_q <= word;
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: receives a byte stream, assembles 32-bit words and
// writes them to instruction memory until the HALT word is seen or the
// memory is full.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned  NB        = 32,
    parameter int unsigned  TAM       = 256,
    parameter int unsigned  NB_BYTE   = 8,
    parameter logic [NB-1:0] HALT_WORD = NB'(HALT_WORD_DEFAULT)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_BYTE-1:0]     i_rx_data,
    input  logic                   i_rx_valid,
    output logic                   o_rx_ready,
    output logic                   o_wr_en,
    output logic [NB-1:0]          o_wr_addr,
    output logic [NB-1:0]          o_wr_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overflow,
    output logic [$clog2(TAM):0]   o_word_count
);

    localparam int unsigned CW    = $clog2(TAM) + 1;
    localparam logic [CW-1:0] TAM_W = CW'(TAM);

    loader_state_t state_q;
    logic [CW-1:0] word_idx_q;
    logic [CW-1:0] word_idx_inc;
    logic [CW-1:0] word_count_q;
    logic          wr_en_q;
    logic [NB-1:0] wr_addr_q;
    logic [NB-1:0] wr_data_q;
    logic          overflow_q;

    logic          accept;
    logic          start_ok;
    logic [NB-1:0] asm_word;
    logic          asm_word_ready;

    assign accept       = i_rx_valid && (state_q == StReceive);
    assign start_ok     = i_start && ((state_q == StIdle) || (state_q == StDone));
    assign word_idx_inc = word_idx_q + CW'(1);

    byte_assembler #(
        .NB      (NB),
        .NB_BYTE (NB_BYTE)
    ) u_byte_assembler (
        .clk        (i_clk),
        .rst        (i_reset),
        .rx_byte    (i_rx_data),
        .accept     (accept),
        .clear      (start_ok),
        .word       (asm_word),
        .word_ready (asm_word_ready)
    );

    // Session FSM with registered write port and status.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            word_idx_q   <= '0;
            word_count_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (i_start) begin
                        word_idx_q   <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        state_q      <= StReceive;
                    end
                end
                StReceive: begin
                    if (asm_word_ready) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= NB'(word_idx_q) << 2;
                        wr_data_q <= asm_word;
                        state_q   <= StWrite;
                    end
                end
                StWrite: begin
                    word_count_q <= word_count_q + CW'(1);
                    if (wr_data_q == HALT_WORD) begin
                        state_q <= StDone;
                    end else if (word_idx_inc == TAM_W) begin
                        overflow_q <= 1'b1;
                        state_q    <= StDone;
                    end else begin
                        word_idx_q <= word_idx_inc;
                        state_q    <= StReceive;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_rx_ready   = (state_q == StReceive);
    assign o_busy       = (state_q == StReceive) || (state_q == StWrite);
    assign o_done       = (state_q == StDone);
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_overflow   = overflow_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: directed scenarios plus randomized
// sessions, with expected memory writes queued by the stimulus and checked
// by an independent write monitor.
module tb_instruction_loader;

    localparam int unsigned NB   = 32;
    localparam int unsigned TAM  = 4;
    localparam int unsigned CW   = $clog2(TAM) + 1;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [CW-1:0] word_count;

    instruction_loader #(
        .NB        (NB),
        .TAM       (TAM),
        .NB_BYTE   (8),
        .HALT_WORD (HALT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_overflow   (overflow),
        .o_word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // Reference model: session-level view of the loader.
    int          m_idx;
    int          m_count;
    bit          m_active;
    bit          m_done;
    bit          m_ovf;
    logic [31:0] m_last_addr;
    logic [31:0] m_last_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    fails++;
                    $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic model_reset();
        m_idx = 0; m_count = 0; m_active = 0; m_done = 0; m_ovf = 0;
        m_last_addr = '0; m_last_data = '0;
    endtask

    task automatic check_zero();
        check("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("rst_wr_en", {63'd0, wr_en}, 64'd0);
        check("rst_wr_addr", {32'd0, wr_addr}, 64'd0);
        check("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check("rst_flags", {61'd0, busy, done, overflow}, 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
    endtask

    // Compare status outputs against the model (outside the WRITE cycle).
    task automatic check_status(input string tag);
        check({tag, "_done"}, {63'd0, done}, {63'd0, m_done});
        check({tag, "_overflow"}, {63'd0, overflow}, {63'd0, m_ovf});
        check({tag, "_word_count"}, 64'(word_count), 64'(m_count));
        check({tag, "_busy"}, {63'd0, busy}, {63'd0, m_active});
        check({tag, "_rx_ready"}, {63'd0, rx_ready}, {63'd0, m_active});
        check({tag, "_wr_addr_hold"}, {32'd0, wr_addr}, {32'd0, m_last_addr});
        check({tag, "_wr_data_hold"}, {32'd0, wr_data}, {32'd0, m_last_data});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0;
        #2;
        check_zero();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_zero();
    endtask

    task automatic pulse_start();
        if (!m_active) begin
            m_idx = 0; m_count = 0; m_ovf = 0; m_done = 0; m_active = 1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer a byte and wait (bounded) for the handshake.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        rx_data = b; rx_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check("handshake", {63'd0, ok}, 64'd1);
    endtask

    // Drive bytes while the loader is not receiving; none may be taken.
    task automatic junk_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            rx_data = 8'($urandom); rx_valid = 1'b1;
            @(negedge clk);
            check("idle_rx_ready", {63'd0, rx_ready}, 64'd0);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit hold);
        bit ok;
        wr_t e;
        e.addr = 32'(m_idx * 4);
        e.data = w;
        exp_q.push_back(e);
        for (int b = 3; b >= 0; b--) begin
            send_byte(w[b*8 +: 8], ok);
            if (!ok) return;
        end
        if (hold) begin
            rx_data = 8'($urandom); rx_valid = 1'b1;
        end
        @(negedge clk);
        check("write_latency", {63'd0, wr_en}, 64'd1);
        check("write_rx_ready", {63'd0, rx_ready}, 64'd0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        m_count++;
        m_last_addr = e.addr;
        m_last_data = w;
        if (w == HALT) begin
            m_done = 1; m_active = 0;
        end else if (m_idx + 1 == TAM) begin
            m_done = 1; m_active = 0; m_ovf = 1;
        end else begin
            m_idx++;
        end
        check_status("word");
    endtask

    task automatic partial_then_reset(input int n);
        bit ok;
        for (int i = 0; i < n; i++) send_byte(8'($urandom), ok);
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; rx_data = '0; rx_valid = 1'b0;
        model_reset();
        do_reset();

        // Bytes in IDLE are ignored.
        junk_bytes(3);

        // Single word, then two more ending in HALT.
        pulse_start();
        check_status("start");
        send_word(32'h2008_0005, 1'b0);
        send_word(32'h1234_5678, 1'b1);
        send_word(HALT, 1'b0);
        check_status("halt");

        // Bytes in DONE are ignored and status holds.
        junk_bytes(3);
        check_status("done_hold");

        // New session from DONE; a start pulse mid-session is ignored; fill to overflow.
        pulse_start();
        check_status("restart");
        send_word(32'hA5A5_0001, 1'b1);
        pulse_start();
        send_word(32'hA5A5_0002, 1'b0);
        send_word(32'hA5A5_0003, 1'b1);
        send_word(32'hA5A5_0004, 1'b0);
        check_status("overflow");

        // Reset in the middle of a word, then reload from address 0.
        pulse_start();
        partial_then_reset(2);
        junk_bytes(2);
        pulse_start();
        send_word(32'hDEAD_BEEF, 1'b0);
        send_word(HALT, 1'b0);

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            pulse_start();
            while (m_active) begin
                logic [31:0] w;
                w = $urandom;
                if ($urandom_range(0, 5) == 0) w = HALT;
                if ($urandom_range(0, 12) == 0) begin
                    partial_then_reset($urandom_range(1, 3));
                    break;
                end
                if ($urandom_range(0, 4) == 0) pulse_start();
                send_word(w, 1'($urandom_range(0, 1)));
            end
            check_status("session");
            if ($urandom_range(0, 3) == 0) junk_bytes($urandom_range(1, 3));
        end

        repeat (3) @(posedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
